dda_ray_sender: RTL and testbench

//  Producer end of the DDA-result AXI-stream: takes per-ray results from the DDA core,

---
 rtl/dda_pkg.sv | 25 ++
 rtl/axis_skid_buffer.sv | 58 +++++
 rtl/dda_ray_sender.sv | 114 +++++++++++
 tb/tb_dda_ray_sender.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dda_pkg.sv
// Shared widths, ray word layout and sender FSM states
// for the DDA result stream.
package dda_pkg;

  localparam int DDA_COL_W    = 9;
  localparam int DDA_HEIGHT_W = 8;
  localparam int DDA_MAP_W    = 4;
  localparam int DDA_WALLX_W  = 16;
  localparam int DDA_WORD_W   = 38;

  typedef struct packed {
    logic [DDA_COL_W-1:0]    col;
    logic [DDA_HEIGHT_W-1:0] height;
    logic                    wall_type;
    logic [DDA_MAP_W-1:0]    map_data;
    logic [DDA_WALLX_W-1:0]  wall_x;
  } dda_ray_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } sender_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream buffer; input ready comes
// straight from the registered occupancy count.
module axis_skid_buffer #(
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count;
  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = e0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= in_data;
          else               e1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves while new word arrives
          if (count == 2'd1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dda_ray_sender.sv
// Packs DDA ray results into column-tagged stream words,
// one frame of NUM_RAYS beats per frame_start pulse.
module dda_ray_sender
  import dda_pkg::*;
#(
  parameter int NUM_RAYS        = 320,
  parameter int LINE_HEIGHT_MAX = 180,
  parameter int RAW_H_W         = 11
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_n_in,
  input  logic                  frame_start_in,
  input  logic                  ray_valid_in,
  output logic                  ray_ready_out,
  input  logic [RAW_H_W-1:0]    line_height_raw_in,
  input  logic                  wall_type_in,
  input  logic [DDA_MAP_W-1:0]  map_data_in,
  input  logic [DDA_WALLX_W-1:0] wall_x_in,
  output logic                  m_axis_tvalid_out,
  input  logic                  m_axis_tready_in,
  output logic [DDA_WORD_W-1:0] m_axis_tdata_out,
  output logic                  m_axis_tlast_out,
  output logic                  frame_done_out,
  output logic                  frame_overrun_out
);

  localparam logic [DDA_COL_W-1:0] LAST_COL =
    DDA_COL_W'(NUM_RAYS - 1);
  localparam logic [RAW_H_W-1:0] RAW_MAX =
    RAW_H_W'(LINE_HEIGHT_MAX);
  localparam logic [DDA_HEIGHT_W-1:0] H_MAX =
    DDA_HEIGHT_W'(LINE_HEIGHT_MAX);

  sender_state_t        state;
  logic [DDA_COL_W-1:0] col;
  logic                 overrun;
  logic [DDA_HEIGHT_W-1:0] height;
  dda_ray_t             ray;
  logic                 last_col;
  logic                 buf_ready;
  logic                 push;
  logic                 drain_done;

  always_comb begin
    height = line_height_raw_in[DDA_HEIGHT_W-1:0];
    if (line_height_raw_in > RAW_MAX) height = H_MAX;
  end

  assign ray = '{
    col:       col,
    height:    height,
    wall_type: wall_type_in,
    map_data:  map_data_in,
    wall_x:    wall_x_in
  };

  assign last_col   = (col == LAST_COL);
  assign ray_ready_out = (state == S_STREAM) && buf_ready;
  assign push       = ray_valid_in && ray_ready_out;
  assign drain_done = (state == S_DRAIN) && !m_axis_tvalid_out;

  assign frame_done_out    = drain_done;
  assign frame_overrun_out = overrun;

  axis_skid_buffer #(.WIDTH(DDA_WORD_W + 1)) u_skid (
    .clk       (clk_pixel_in),
    .rst_n     (rst_n_in),
    .in_valid  (push),
    .in_ready  (buf_ready),
    .in_data   ({last_col, ray}),
    .out_valid (m_axis_tvalid_out),
    .out_ready (m_axis_tready_in),
    .out_data  ({m_axis_tlast_out, m_axis_tdata_out})
  );

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= S_IDLE;
      col     <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (frame_start_in) begin
            state <= S_STREAM;
            col   <= '0;
          end
        end
        S_STREAM: begin
          if (frame_start_in) overrun <= 1'b1;
          if (push) begin
            if (last_col) begin
              col   <= '0;
              state <= S_DRAIN;
            end else begin
              col <= col + DDA_COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // A start landing on completion chains frames
          if (drain_done) begin
            col   <= '0;
            state <= frame_start_in ? S_STREAM : S_IDLE;
          end else if (frame_start_in) begin
            overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dda_ray_sender.sv
// Directed bench for dda_ray_sender with a scoreboard
// of expected stream words.
module tb_dda_ray_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        ray_valid = 1'b0;
  logic        ray_ready;
  logic [10:0] raw = '0;
  logic        wt = 1'b0;
  logic [3:0]  mp = '0;
  logic [15:0] wx = '0;
  logic        tvalid;
  logic        tready = 1'b1;
  logic [37:0] tdata;
  logic        tlast;
  logic        done;
  logic        overrun;

  int total = 0;
  int passed = 0;
  int k = 0;
  int exp_col = 0;
  int beats = 0;
  int pushes = 0;
  int done_cnt = 0;
  int mode = 0;
  int frame_no = 0;
  logic exp_done = 1'b0;
  logic hold = 1'b0;
  logic [38:0] held = '0;
  logic [38:0] q[$];

  dda_ray_sender dut (
    .clk_pixel_in       (clk),
    .rst_n_in           (rst_n),
    .frame_start_in     (frame_start),
    .ray_valid_in       (ray_valid),
    .ray_ready_out      (ray_ready),
    .line_height_raw_in (raw),
    .wall_type_in       (wt),
    .map_data_in        (mp),
    .wall_x_in          (wx),
    .m_axis_tvalid_out  (tvalid),
    .m_axis_tready_in   (tready),
    .m_axis_tdata_out   (tdata),
    .m_axis_tlast_out   (tlast),
    .frame_done_out     (done),
    .frame_overrun_out  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply(int n);
    logic [31:0] v;
    v = n;
    raw = 11'((n * 37) % 1200);
    wt = v[0];
    mp = v[3:0];
    wx = 16'(n * 4660);
    if (n == 0) raw = 11'd1000;
    if (n == 1) raw = 11'd179;
    if (n == 2) raw = 11'd180;
    if (n == 5) begin
      raw = 11'd42;
      wt = 1'b1;
      mp = 4'hA;
      wx = 16'h8000;
    end
  endtask

  function automatic logic [38:0] model(int c);
    logic [7:0] h;
    h = (raw > 11'd180) ? 8'd180 : raw[7:0];
    return {c == 319, 9'(c), h, wt, mp, wx};
  endfunction

  task automatic step();
    logic pushed;
    logic [38:0] e;
    @(negedge clk);
    if (hold) begin
      chk("hold_valid", 64'(tvalid), 64'd1);
      chk("hold_data", 64'({tlast, tdata}), 64'(held));
    end
    chk("frame_done", 64'(done), 64'(exp_done));
    if (done) done_cnt++;
    exp_done = 1'b0;
    if (tvalid && tready) begin
      if (q.size() == 0) begin
        chk("beat_unexpected", 64'(tdata), 64'h3fffffffff);
      end else begin
        e = q.pop_front();
        chk("beat", 64'({tlast, tdata}), 64'(e));
        if (e[38]) exp_done = 1'b1;
        if (frame_no == 1) begin
          if (e[37:29] == 9'd0)
            chk("sat_1000", 64'(tdata[28:21]), 64'd180);
          if (e[37:29] == 9'd1)
            chk("sat_179", 64'(tdata[28:21]), 64'd179);
          if (e[37:29] == 9'd2)
            chk("sat_180", 64'(tdata[28:21]), 64'd180);
          if (e[37:29] == 9'd5)
            chk("word_col5", 64'(tdata), 64'hA55A8000);
        end
      end
      beats++;
    end
    pushed = ray_valid && ray_ready;
    if (pushed) begin
      q.push_back(model(exp_col));
      exp_col = (exp_col == 319) ? 0 : exp_col + 1;
      pushes++;
    end
    hold = tvalid && !tready && rst_n;
    held = {tlast, tdata};
    @(posedge clk);
    #1;
    if (pushed) begin
      k++;
      apply(k);
    end
    if (mode == 0) tready = 1'b1;
    else if (mode == 1) tready = ~tready;
    else tready = 1'b0;
  endtask

  task automatic start_frame();
    exp_col = 0;
    beats = 0;
    pushes = 0;
    done_cnt = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_until_done(int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
  endtask

  initial begin
    apply(0);
    ray_valid = 1'b1;
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_ready", 64'(ray_ready), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("idle_ready", 64'(ray_ready), 64'd0);
    chk("idle_tvalid", 64'(tvalid), 64'd0);

    frame_no = 1;
    mode = 0;
    start_frame();
    chk("stream_ready", 64'(ray_ready), 64'd1);
    chk("lat_n", 64'(tvalid), 64'd0);
    step();
    chk("lat_n1", 64'(tvalid), 64'd1);
    run_until_done(600);
    chk("f1_done", 64'(done_cnt), 64'd1);
    chk("f1_beats", 64'(beats), 64'd320);
    chk("f1_queue", 64'(q.size()), 64'd0);
    chk("f1_idle_ready", 64'(ray_ready), 64'd0);

    frame_no = 2;
    mode = 1;
    start_frame();
    run_until_done(1400);
    chk("f2_done", 64'(done_cnt), 64'd1);
    chk("f2_beats", 64'(beats), 64'd320);
    chk("f2_queue", 64'(q.size()), 64'd0);

    frame_no = 3;
    mode = 2;
    tready = 1'b0;
    start_frame();
    for (int j = 0; j < 50; j++) begin
      step();
      if (j == 1) chk("full_ready_c3", 64'(ray_ready), 64'd0);
    end
    chk("stall_pushes", 64'(pushes), 64'd2);
    chk("stall_beats", 64'(beats), 64'd0);
    chk("stall_ready", 64'(ray_ready), 64'd0);
    chk("stall_tvalid", 64'(tvalid), 64'd1);
    mode = 0;
    tready = 1'b1;
    for (int i = 0; i < 400 && exp_col != 100; i++) step();
    chk("reach_col100", 64'(exp_col), 64'd100);
    chk("pre_overrun", 64'(overrun), 64'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    chk("overrun_set", 64'(overrun), 64'd1);
    repeat (20) step();
    chk("col_continue", 64'(exp_col), 64'd122);
    chk("overrun_sticky", 64'(overrun), 64'd1);

    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    chk("mid_rst_ready", 64'(ray_ready), 64'd0);
    q.delete();
    hold = 1'b0;
    exp_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    frame_no = 4;
    mode = 0;
    start_frame();
    run_until_done(600);
    chk("f4_done", 64'(done_cnt), 64'd1);
    chk("f4_beats", 64'(beats), 64'd320);
    chk("f4_queue", 64'(q.size()), 64'd0);
    chk("f4_overrun", 64'(overrun), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
